// File: rtl/proc_mem_io_if.sv
// Processor-side bus of the 9-bit machine:
// registered address, write data and strobe out, read data back.
interface proc_mem_io_if #(
  parameter int DATA_W = 9
);
  logic [8:0]        Addr;
  logic [DATA_W-1:0] DOUT;
  logic              W;
  logic [DATA_W-1:0] DIN;

  modport master (
    output Addr,
    output DOUT,
    output W,
    input  DIN
  );

  modport slave (
    input  Addr,
    input  DOUT,
    input  W,
    output DIN
  );
endinterface

// File: rtl/proc_mem_io.sv
// Memory and I/O subsystem: RAM, LED register, reload timer
// with sticky expiry flag, and synchronised switch port.
module proc_mem_io #(
  parameter int DATA_W = 9,
  parameter int RAM_AW = 7
) (
  input  logic              Clock,
  input  logic              Resetn,
  proc_mem_io_if.slave      bus,
  input  logic [DATA_W-1:0] SW,
  output logic [DATA_W-1:0] LEDR,
  output logic              Tirq
);

  logic [DATA_W-1:0] mem [2**RAM_AW];

  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] led_q, led_d;
  logic [DATA_W-1:0] load_q, load_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic              en_q, en_d;
  logic              exp_q, exp_d;
  logic [DATA_W-1:0] sw1_q, sw2_q;

  logic              hit_ram, hit_led;
  logic              hit_tmr, hit_sw;
  logic [1:0]        tsel;
  logic [RAM_AW-1:0] idx;
  logic              load_wr, ctrl_wr;
  logic [DATA_W-1:0] status;

  assign hit_ram = bus.Addr[8:7] == 2'b00;
  assign hit_led = bus.Addr[8:7] == 2'b01;
  assign hit_tmr = bus.Addr[8:7] == 2'b10;
  assign hit_sw  = bus.Addr[8:7] == 2'b11;
  assign tsel    = bus.Addr[1:0];
  assign idx     = bus.Addr[RAM_AW-1:0];

  assign load_wr = bus.W && hit_tmr
                && tsel == 2'b00;
  assign ctrl_wr = bus.W && hit_tmr
                && tsel == 2'b01;

  always_comb begin
    status            = '0;
    status[DATA_W-1]  = exp_q;
    status[0]         = en_q;
  end

  // Read mux samples pre-edge state, giving read-before-write
  always_comb begin
    din_d = '0;
    unique case (1'b1)
      hit_ram: din_d = mem[idx];
      hit_led: din_d = led_q;
      hit_tmr: begin
        unique case (tsel)
          2'b00:   din_d = load_q;
          2'b01:   din_d = status;
          2'b10:   din_d = cnt_q;
          default: din_d = '0;
        endcase
      end
      hit_sw:  din_d = sw2_q;
      default: din_d = '0;
    endcase
  end

  always_comb begin
    led_d = led_q;
    if (bus.W && hit_led)
      led_d = bus.DOUT;
  end

  // Expiry set is applied after the clear so it wins
  always_comb begin
    load_d = load_q;
    cnt_d  = cnt_q;
    en_d   = en_q;
    exp_d  = exp_q;
    if (ctrl_wr) begin
      en_d = bus.DOUT[0];
      if (bus.DOUT[DATA_W-1])
        exp_d = 1'b0;
    end
    if (load_wr) begin
      load_d = bus.DOUT;
      cnt_d  = bus.DOUT;
    end else if (en_q) begin
      if (cnt_q == '0) begin
        cnt_d = load_q;
        exp_d = 1'b1;
      end else begin
        cnt_d = cnt_q - DATA_W'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (bus.W && hit_ram)
      mem[idx] <= bus.DOUT;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      din_q  <= '0;
      led_q  <= '0;
      load_q <= '0;
      cnt_q  <= '0;
      en_q   <= 1'b0;
      exp_q  <= 1'b0;
      sw1_q  <= '0;
      sw2_q  <= '0;
    end else begin
      din_q  <= din_d;
      led_q  <= led_d;
      load_q <= load_d;
      cnt_q  <= cnt_d;
      en_q   <= en_d;
      exp_q  <= exp_d;
      sw1_q  <= SW;
      sw2_q  <= sw1_q;
    end
  end

  assign bus.DIN = din_q;
  assign LEDR    = led_q;
  assign Tirq    = exp_q;

endmodule

// File: tb/tb_proc_mem_io.sv
// Bench for proc_mem_io: directed scenarios plus random
// traffic against a behavioural model of the address map.
module tb_proc_mem_io;

  logic       Clock;
  logic       Resetn;
  logic [8:0] sw;
  logic [8:0] ledr;
  logic       tirq;

  proc_mem_io_if #(.DATA_W(9)) bus ();

  proc_mem_io #(.DATA_W(9), .RAM_AW(7)) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .bus   (bus.slave),
    .SW    (sw),
    .LEDR  (ledr),
    .Tirq  (tirq)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;

  logic [8:0] m_mem [128];
  bit         m_val [128];
  logic [8:0] m_led, m_load, m_cnt;
  logic       m_en, m_exp;
  logic [8:0] m_s1, m_s2;
  logic [8:0] m_din;
  bit         m_known;

  task automatic model_reset();
    m_led = 0; m_load = 0; m_cnt = 0;
    m_en = 0; m_exp = 0;
    m_s1 = 0; m_s2 = 0;
    m_din = 0; m_known = 1;
  endtask

  // one bus cycle: drive, clock, then advance the model
  task automatic step(input logic [8:0] a,
                      input logic [8:0] d,
                      input logic w);
    logic [8:0] rd;
    bit         kn;
    logic [8:0] n_load, n_cnt;
    logic       n_en, n_exp;
    bus.Addr = a; bus.DOUT = d; bus.W = w;
    kn = 1; rd = 0;
    case (a[8:7])
      2'd0: begin
        rd = m_mem[a[6:0]];
        kn = m_val[a[6:0]];
      end
      2'd1: rd = m_led;
      2'd2: case (a[1:0])
        2'd0: rd = m_load;
        2'd1: rd = {m_exp, 7'd0, m_en};
        2'd2: rd = m_cnt;
        default: rd = 0;
      endcase
      default: rd = m_s2;
    endcase
    n_load = m_load; n_cnt = m_cnt;
    n_en = m_en; n_exp = m_exp;
    if (w && a[8:7] == 2'd2 && a[1:0] == 2'd1) begin
      n_en = d[0];
      if (d[8]) n_exp = 0;
    end
    if (w && a[8:7] == 2'd2 && a[1:0] == 2'd0) begin
      n_load = d; n_cnt = d;
    end else if (m_en) begin
      if (m_cnt == 0) begin
        n_cnt = m_load; n_exp = 1;
      end else begin
        n_cnt = m_cnt - 9'd1;
      end
    end
    @(posedge Clock);
    #1;
    m_din = rd; m_known = kn;
    if (w && a[8:7] == 2'd0) begin
      m_mem[a[6:0]] = d; m_val[a[6:0]] = 1;
    end
    if (w && a[8:7] == 2'd1) m_led = d;
    m_load = n_load; m_cnt = n_cnt;
    m_en = n_en; m_exp = n_exp;
    m_s2 = m_s1; m_s1 = sw;
  endtask

  task automatic test_reset();
    Resetn = 0; sw = 0;
    bus.Addr = 9'h101; bus.DOUT = 0; bus.W = 0;
    model_reset();
    #1;
    checks++;
    if (bus.DIN !== 9'h000 || ledr !== 9'h000 || tirq !== 1'b0) begin
      failures++;
      $display("FAIL por din=%h ledr=%h tirq=%b exp=0", bus.DIN, ledr, tirq);
    end
    @(negedge Clock);
    Resetn = 1;
    step(9'h080, 9'h1C3, 1);
    step(9'h080, 9'h000, 0);
    checks++;
    if (bus.DIN !== 9'h1C3 || ledr !== 9'h1C3) begin
      failures++;
      $display("FAIL pre_rst din=%h ledr=%h exp=1c3", bus.DIN, ledr);
    end
    bus.Addr = 9'h0AB;
    #2;
    Resetn = 0;
    #1;
    checks++;
    if (bus.DIN !== 9'h000 || ledr !== 9'h000 || tirq !== 1'b0) begin
      failures++;
      $display("FAIL async_rst din=%h ledr=%h tirq=%b exp=0", bus.DIN, ledr, tirq);
    end
    model_reset();
    @(negedge Clock);
    Resetn = 1;
    step(9'h101, 9'h000, 0);
    checks++;
    if (bus.DIN !== 9'h000) begin
      failures++;
      $display("FAIL rst_ctrl din=%h exp=000", bus.DIN);
    end
  endtask

  task automatic test_ram();
    step(9'h005, 9'h1A5, 1);
    step(9'h07F, 9'h0FF, 1);
    step(9'h005, 9'h000, 0);
    checks++;
    if (bus.DIN !== 9'h1A5) begin
      failures++;
      $display("FAIL ram_rd5 din=%h exp=1a5", bus.DIN);
    end
    step(9'h07F, 9'h000, 0);
    checks++;
    if (bus.DIN !== 9'h0FF) begin
      failures++;
      $display("FAIL ram_rd7f din=%h exp=0ff", bus.DIN);
    end
    step(9'h005, 9'h033, 1);
    checks++;
    if (bus.DIN !== 9'h1A5) begin
      failures++;
      $display("FAIL ram_rbw din=%h exp=1a5", bus.DIN);
    end
    step(9'h005, 9'h000, 0);
    checks++;
    if (bus.DIN !== 9'h033) begin
      failures++;
      $display("FAIL ram_new din=%h exp=033", bus.DIN);
    end
  endtask

  task automatic test_led();
    step(9'h080, 9'h155, 1);
    checks++;
    if (ledr !== 9'h155) begin
      failures++;
      $display("FAIL led_wr ledr=%h exp=155", ledr);
    end
    step(9'h0FE, 9'h000, 0);
    checks++;
    if (bus.DIN !== 9'h155) begin
      failures++;
      $display("FAIL led_alias din=%h exp=155", bus.DIN);
    end
  endtask

  task automatic test_timer();
    logic [8:0] cseq [5];
    logic       tseq [5];
    cseq = '{9'd3, 9'd2, 9'd1, 9'd0, 9'd3};
    tseq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    step(9'h100, 9'h003, 1);
    step(9'h101, 9'h001, 1);
    for (int i = 0; i < 5; i++) begin
      step(9'h102, 9'h000, 0);
      checks++;
      if (bus.DIN !== cseq[i] || tirq !== tseq[i]) begin
        failures++;
        $display("FAIL tmr_cnt%0d din=%h tirq=%b exp=%h/%b", i, bus.DIN, tirq, cseq[i], tseq[i]);
      end
    end
  endtask

  task automatic test_timer_clear();
    step(9'h101, 9'h101, 1);
    checks++;
    if (tirq !== 1'b0) begin
      failures++;
      $display("FAIL clr_idle tirq=%b exp=0", tirq);
    end
    step(9'h102, 9'h000, 0);
    step(9'h101, 9'h101, 1);
    checks++;
    if (tirq !== 1'b1) begin
      failures++;
      $display("FAIL clr_vs_set tirq=%b exp=1", tirq);
    end
    step(9'h101, 9'h000, 1);
    for (int i = 0; i < 3; i++) begin
      step(9'h102, 9'h000, 0);
      checks++;
      if (bus.DIN !== 9'd2 || tirq !== 1'b1) begin
        failures++;
        $display("FAIL freeze%0d din=%h tirq=%b exp=002/1", i, bus.DIN, tirq);
      end
    end
    step(9'h101, 9'h000, 0);
    checks++;
    if (bus.DIN !== 9'h100) begin
      failures++;
      $display("FAIL status din=%h exp=100", bus.DIN);
    end
  endtask

  task automatic test_switch();
    logic [8:0] seq [3];
    seq = '{9'h000, 9'h000, 9'h0AA};
    sw = 9'h000;
    step(9'h180, 9'h000, 0);
    step(9'h180, 9'h000, 0);
    sw = 9'h0AA;
    for (int i = 0; i < 3; i++) begin
      step(9'h180, 9'h000, 0);
      checks++;
      if (bus.DIN !== seq[i]) begin
        failures++;
        $display("FAIL sw_edge%0d din=%h exp=%h", i + 1, bus.DIN, seq[i]);
      end
    end
    step(9'h180, 9'h1FF, 1);
    checks++;
    if (bus.DIN !== 9'h0AA) begin
      failures++;
      $display("FAIL sw_wr din=%h exp=0aa", bus.DIN);
    end
  endtask

  task automatic test_random();
    logic [8:0] a, d;
    logic       w;
    for (int i = 0; i < 400; i++) begin
      a = 9'($urandom);
      d = 9'($urandom);
      w = 1'($urandom_range(0, 1));
      if (a[8:7] == 2'd2 && a[1:0] == 2'd0)
        d = 9'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0)
        sw = 9'($urandom);
      step(a, d, w);
      checks++;
      if ((m_known && bus.DIN !== m_din) || ledr !== m_led || tirq !== m_exp) begin
        failures++;
        $display("FAIL rand%0d a=%h din=%h/%h ledr=%h/%h tirq=%b/%b", i, a, bus.DIN, m_din, ledr, m_led, tirq, m_exp);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) m_val[i] = 0;
    test_reset();
    test_ram();
    test_led();
    test_timer();
    test_timer_clear();
    test_switch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
